// File: rtl/traffic_mode_ctrl.sv
// Traffic mode selector: picks DAY/NIGHT/PED/EMG from latched pedestrian requests,
// emergency requests and a debounced day/night flag; all outputs are registered.
module traffic_mode_ctrl #(
  parameter int NUM_PED    = 4,
  parameter int CNT_W      = 8,
  parameter int MIN_DWELL  = 16,
  parameter int PED_CYCLES = 32,
  parameter int EMG_HOLD   = 8,
  parameter int DN_FILT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PED-1:0] ped_req,
  input  logic               emg_req,
  input  logic               day_time,
  output logic [1:0]         mode,
  output logic [NUM_PED-1:0] ped_pending,
  output logic [NUM_PED-1:0] ped_served,
  output logic               mode_change,
  output logic [CNT_W-1:0]   dwell_cnt
);

  typedef enum logic [1:0] {
    MODE_DAY   = 2'b00,
    MODE_NIGHT = 2'b01,
    MODE_PED   = 2'b10,
    MODE_EMG   = 2'b11
  } mode_e;

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (MIN_DWELL < 1 || MIN_DWELL > CNT_MAX || PED_CYCLES < 1 || PED_CYCLES > CNT_MAX ||
      EMG_HOLD < 1 || EMG_HOLD > CNT_MAX || DN_FILT < 1 || DN_FILT > CNT_MAX) begin : g_param_err
    $error("traffic_mode_ctrl: timing parameters must lie in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DWELL_MIN_C = CNT_W'(MIN_DWELL - 1);
  localparam logic [CNT_W-1:0] PED_LAST_C  = CNT_W'(PED_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD_C = CNT_W'(EMG_HOLD - 1);
  localparam logic [CNT_W-1:0] FILT_LAST_C = CNT_W'(DN_FILT - 1);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] SAT_C       = {CNT_W{1'b1}};

  mode_e              mode_q, mode_d;
  logic               dn_flag_q, dn_flag_d;
  logic [CNT_W-1:0]   filt_q, filt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [NUM_PED-1:0] pending_q, pending_d;
  logic [NUM_PED-1:0] served_pulse_q, served_pulse_d;
  logic [NUM_PED-1:0] served_q, served_d;
  logic               change_q, change_d;

  logic               dwell_ok_s;
  logic               pend_any_s;
  logic               ped_enter_s;
  logic [NUM_PED-1:0] pend_all_s;
  mode_e              dn_mode_s;

  // Next-state: day/night filter, mode selection, counters and request bookkeeping.
  always_comb begin
    dn_flag_d      = dn_flag_q;
    filt_d         = ZERO_C;
    hold_d         = hold_q;
    mode_d         = mode_q;
    dwell_d        = dwell_q;
    pending_d      = pending_q;
    served_pulse_d = {NUM_PED{1'b0}};
    served_d       = served_q;
    change_d       = 1'b0;

    dwell_ok_s = (dwell_q >= DWELL_MIN_C);
    pend_any_s = (pending_q != {NUM_PED{1'b0}});
    pend_all_s = pending_q | ped_req;
    dn_mode_s  = dn_flag_q ? MODE_DAY : MODE_NIGHT;

    if (day_time != dn_flag_q) begin
      if (filt_q == FILT_LAST_C) begin
        dn_flag_d = ~dn_flag_q;
        filt_d    = ZERO_C;
      end else begin
        filt_d = filt_q + ONE_C;
      end
    end else begin
      filt_d = ZERO_C;
    end

    if (emg_req) begin
      hold_d = HOLD_LOAD_C;
    end else if (hold_q != ZERO_C) begin
      hold_d = hold_q - ONE_C;
    end else begin
      hold_d = hold_q;
    end

    if (emg_req) begin
      mode_d = MODE_EMG;
    end else begin
      case (mode_q)
        MODE_DAY: begin
          if (pend_any_s && dwell_ok_s)     mode_d = MODE_PED;
          else if (!dn_flag_q && dwell_ok_s) mode_d = MODE_NIGHT;
          else                               mode_d = MODE_DAY;
        end
        MODE_NIGHT: begin
          if (pend_any_s && dwell_ok_s)     mode_d = MODE_PED;
          else if (dn_flag_q && dwell_ok_s) mode_d = MODE_DAY;
          else                              mode_d = MODE_NIGHT;
        end
        MODE_PED: begin
          if (dwell_q == PED_LAST_C) mode_d = dn_mode_s;
          else                       mode_d = MODE_PED;
        end
        MODE_EMG: begin
          if (hold_q != ZERO_C)  mode_d = MODE_EMG;
          else if (pend_any_s)   mode_d = MODE_PED;
          else                   mode_d = dn_mode_s;
        end
        default: mode_d = MODE_DAY;
      endcase
    end

    change_d = (mode_d != mode_q);
    if (change_d) begin
      dwell_d = ZERO_C;
    end else if (dwell_q != SAT_C) begin
      dwell_d = dwell_q + ONE_C;
    end else begin
      dwell_d = dwell_q;
    end

    // An EMG abort of PED hands the granted channels back so they are served next time.
    ped_enter_s = (mode_d == MODE_PED) && (mode_q != MODE_PED);
    if (ped_enter_s) begin
      served_pulse_d = pend_all_s;
      served_d       = pend_all_s;
      pending_d      = {NUM_PED{1'b0}};
    end else if (mode_q == MODE_PED && mode_d == MODE_EMG) begin
      pending_d = pend_all_s | served_q;
    end else begin
      pending_d = pend_all_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= MODE_DAY;
      dn_flag_q      <= 1'b1;
      filt_q         <= ZERO_C;
      hold_q         <= ZERO_C;
      dwell_q        <= ZERO_C;
      pending_q      <= {NUM_PED{1'b0}};
      served_pulse_q <= {NUM_PED{1'b0}};
      served_q       <= {NUM_PED{1'b0}};
      change_q       <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      dn_flag_q      <= dn_flag_d;
      filt_q         <= filt_d;
      hold_q         <= hold_d;
      dwell_q        <= dwell_d;
      pending_q      <= pending_d;
      served_pulse_q <= served_pulse_d;
      served_q       <= served_d;
      change_q       <= change_d;
    end
  end

  assign mode        = mode_q;
  assign ped_pending = pending_q;
  assign ped_served  = served_pulse_q;
  assign mode_change = change_q;
  assign dwell_cnt   = dwell_q;

endmodule
